// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Drives a request/ready instruction-memory port and honours Freeze stalls and branch flushes.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Freeze,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_Addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        IF_valid
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_skid;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_valid;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  // In DROP the abandoned request keeps its original address until the
  // memory answers, while r_pc already holds the branch target.
  always_comb begin
    imem_req  = !rst && (r_state != S_HOLD);
    imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_skid      <= '0;
      r_instr     <= NOP_INSTR;
      r_pc_out    <= '0;
      r_valid     <= 1'b0;
    end else if (Branch_taken) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_pc    <= Branch_Addr;
      case (r_state)
        S_REQ: begin
          if (imem_ready) begin
            r_state <= S_REQ;
          end else begin
            r_state     <= S_DROP;
            r_drop_addr <= r_pc;
          end
        end
        S_DROP:  r_state <= imem_ready ? S_REQ : S_DROP;
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_ready) begin
            r_pc <= w_pc_plus4;
            if (Freeze) begin
              r_skid  <= imem_rdata;
              r_state <= S_HOLD;
            end else begin
              r_instr  <= imem_rdata;
              r_pc_out <= w_pc_plus4;
              r_valid  <= 1'b1;
            end
          end else if (!Freeze) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!Freeze) begin
            r_instr  <= r_skid;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_ready) r_state <= S_REQ;
          if (!Freeze) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign instruction = r_instr;
  assign PC          = r_pc_out;
  assign IF_valid    = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus a reset-mid-request sequence.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, Freeze, Branch_taken, imem_ready;
  logic [31:0] Branch_Addr, imem_rdata, imem_addr, instruction, PC;
  logic        imem_req, IF_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .Freeze(Freeze), .Branch_taken(Branch_taken),
    .Branch_Addr(Branch_Addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction),
    .PC(PC), .IF_valid(IF_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] M(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  // Memory model: word content is a function of its address.
  always_comb imem_rdata = imem_ready ? M(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        freeze;
    logic        br;
    logic [31:0] baddr;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[27];

  initial begin
    //            frz br  baddr          rdy req addr          val instr            pc
    tbl[0]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0,        1'b1,M(32'h0),        32'h4};
    tbl[1]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h4,        1'b1,M(32'h4),        32'h8};
    tbl[2]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h8,        1'b1,M(32'h8),        32'hC};
    tbl[3]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'hC,        1'b0,NOP,             32'h0};
    tbl[4]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'hC,        1'b0,NOP,             32'h0};
    tbl[5]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'hC,        1'b1,M(32'hC),        32'h10};
    tbl[6]  = '{1'b1,1'b0,32'h0,        1'b1,1'b1,32'h10,       1'b1,M(32'hC),        32'h10};
    tbl[7]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,M(32'hC),        32'h10};
    tbl[8]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,M(32'hC),        32'h10};
    tbl[9]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,M(32'h10),       32'h14};
    tbl[10] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h14,       1'b1,M(32'h14),       32'h18};
    tbl[11] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h18,       1'b0,NOP,             32'h0};
    tbl[12] = '{1'b0,1'b1,32'h40,       1'b0,1'b1,32'h18,       1'b0,NOP,             32'h0};
    tbl[13] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h18,       1'b0,NOP,             32'h0};
    tbl[14] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h18,       1'b0,NOP,             32'h0};
    tbl[15] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h40,       1'b1,M(32'h40),       32'h44};
    tbl[16] = '{1'b1,1'b0,32'h0,        1'b1,1'b1,32'h44,       1'b1,M(32'h40),       32'h44};
    tbl[17] = '{1'b1,1'b1,32'h80,       1'b0,1'b0,32'h0,        1'b0,NOP,             32'h0};
    tbl[18] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h80,       1'b1,M(32'h80),       32'h84};
    tbl[19] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h84,       1'b0,NOP,             32'h0};
    tbl[20] = '{1'b0,1'b1,32'h100,      1'b0,1'b1,32'h84,       1'b0,NOP,             32'h0};
    tbl[21] = '{1'b0,1'b1,32'h200,      1'b0,1'b1,32'h84,       1'b0,NOP,             32'h0};
    tbl[22] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h84,       1'b0,NOP,             32'h0};
    tbl[23] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h200,      1'b1,M(32'h200),      32'h204};
    tbl[24] = '{1'b0,1'b1,32'hFFFF_FFFC,1'b1,1'b1,32'h204,      1'b0,NOP,             32'h0};
    tbl[25] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'hFFFF_FFFC,1'b1,M(32'hFFFF_FFFC),32'h0};
    tbl[26] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0,        1'b1,M(32'h0),        32'h4};

    rst = 1'b1; Freeze = 1'b0; Branch_taken = 1'b0; Branch_Addr = '0; imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", -1, {31'd0, imem_req}, 32'd0);
    chk("rst_valid", -1, {31'd0, IF_valid}, 32'd0);
    chk("rst_instr", -1, instruction, NOP);
    chk("rst_pc", -1, PC, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      if (i != 0) @(negedge clk);
      Freeze       = tbl[i].freeze;
      Branch_taken = tbl[i].br;
      Branch_Addr  = tbl[i].baddr;
      imem_ready   = tbl[i].ready;
      #1;
      chk("req", i, {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
      if (tbl[i].exp_req) chk("addr", i, imem_addr, tbl[i].exp_addr);
      @(posedge clk);
      #1;
      chk("valid", i, {31'd0, IF_valid}, {31'd0, tbl[i].exp_valid});
      chk("instr", i, instruction, tbl[i].exp_instr);
      if (tbl[i].exp_valid) chk("pc", i, PC, tbl[i].exp_pc);
    end

    // Reset while a request to 0x4 is outstanding: request drops, fetch restarts at RESET_PC.
    @(negedge clk);
    Freeze = 1'b0; Branch_taken = 1'b0; imem_ready = 1'b0;
    #1;
    chk("midrst_pre_addr", 100, imem_addr, 32'h4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req_low", 101, {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_valid", 102, {31'd0, IF_valid}, 32'd0);
    chk("midrst_pc", 102, PC, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_req_up", 103, {31'd0, imem_req}, 32'd1);
    chk("midrst_addr", 103, imem_addr, 32'h0);
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_instr", 104, instruction, M(32'h0));
    chk("midrst_pcout", 104, PC, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
